// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: decode-side valid/stall/redirect stream plus the ROM read port.
// master = fetch unit, slave = decode stage / ROM side.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned PC_WIDTH      = 32
);
   logic                     stall_i;
   logic                     redirect_i;
   logic [PC_WIDTH-1:0]      redirect_pc_i;
   logic [ADDRESS_WIDTH-1:0] imem_addr_o;
   logic [DATA_WIDTH-1:0]    imem_rd_i;
   logic [DATA_WIDTH-1:0]    instr_o;
   logic [PC_WIDTH-1:0]      instr_pc_o;
   logic                     instr_valid_o;
   logic                     fault_o;
   logic [PC_WIDTH-1:0]      fault_pc_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_rd_i,
      output imem_addr_o, instr_o, instr_pc_o, instr_valid_o, fault_o, fault_pc_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_rd_i,
      input  imem_addr_o, instr_o, instr_pc_o, instr_valid_o, fault_o, fault_pc_o
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses a 1-cycle synchronous ROM,
// pairs returned words with their PC, handles stall/redirect, halts on bad PC.
// Optional macro FETCH_PERF_CNT_EN adds consumed-instruction and stall counters.
module instr_fetch_unit #(
   parameter int unsigned       ADDRESS_WIDTH = 5,
   parameter int unsigned       DATA_WIDTH    = 32,
   parameter int unsigned       PC_WIDTH      = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetch_cnt_o,
   output logic [31:0]        perf_stall_cnt_o
`endif
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t              state, state_nxt;
   logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
   logic [PC_WIDTH-1:0] resp_pc, resp_pc_nxt;
   logic [PC_WIDTH-1:0] fault_pc, fault_pc_nxt;
   logic [PC_WIDTH-1:0] addr_pc;
   logic                addr_legal;
   logic                advance;

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= BOOT;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         fault_pc <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         resp_pc  <= resp_pc_nxt;
         fault_pc <= fault_pc_nxt;
      end
   end

   // Issue-address select, legality check and next-state logic
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      resp_pc_nxt  = resp_pc;
      fault_pc_nxt = fault_pc;
      advance      = 1'b0;

      // Stall replays the presented word so the ROM output holds steady
      addr_pc = fetch_pc;
      if (bus.redirect_i) begin
         addr_pc = bus.redirect_pc_i;
      end else if (state == RUN && bus.stall_i) begin
         addr_pc = resp_pc;
      end
      addr_legal = (addr_pc[1:0] == 2'b00) &&
                   (addr_pc[PC_WIDTH-1:ADDRESS_WIDTH+2] == '0);

      case (state)
         BOOT:    advance = 1'b1;
         RUN:     advance = bus.redirect_i || !bus.stall_i;
         HALT:    advance = bus.redirect_i;
         default: advance = 1'b0;
      endcase

      if (advance) begin
         if (addr_legal) begin
            state_nxt    = RUN;
            resp_pc_nxt  = addr_pc;
            fetch_pc_nxt = addr_pc + PC_WIDTH'(4);
         end else begin
            state_nxt    = HALT;
            fault_pc_nxt = addr_pc;
         end
      end
   end

   // Output view of the registered state; ROM data passes straight to decode
   assign bus.imem_addr_o   = addr_pc[ADDRESS_WIDTH+1:2];
   assign bus.instr_o       = bus.imem_rd_i;
   assign bus.instr_pc_o    = resp_pc;
   assign bus.instr_valid_o = (state == RUN);
   assign bus.fault_o       = (state == HALT);
   assign bus.fault_pc_o    = fault_pc;

`ifdef FETCH_PERF_CNT_EN
   // Count consumed instructions and stalled presentation cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch_cnt_o <= '0;
         perf_stall_cnt_o <= '0;
      end else if (state == RUN && !bus.redirect_i) begin
         if (bus.stall_i) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         end else begin
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a transaction-level PC model pushes
// per-cycle expectations; a negedge monitor pops and compares.
module tb_instr_fetch_unit;
   localparam int unsigned AW        = 5;
   localparam int unsigned DW        = 32;
   localparam int unsigned PW        = 32;
   localparam int unsigned ROM_WORDS = 2**AW;
   localparam int unsigned ROM_BYTES = 4*ROM_WORDS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
`endif

   instr_fetch_unit #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW), .RESET_PC(32'h0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt_o (perf_fetch),
      .perf_stall_cnt_o (perf_stall)
`endif
   );

   // Synchronous-read ROM, word i holds 0x1000_0000 + i
   logic [31:0] rom [ROM_WORDS];
   initial for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = 32'h1000_0000 + 32'(i);
   always @(posedge clk) bus.imem_rd_i <= rom[bus.imem_addr_o];

   typedef struct {
      logic        rst;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      logic        chk_fpc;
      logic [31:0] fpc;
      logic [4:0]  addr;
      logic [31:0] pf;
      logic [31:0] ps;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Model: what is on show this cycle and what comes next
   bit          m_boot, m_valid, m_fault;
   logic [31:0] m_pc, m_nxt, m_fpc, m_pf, m_ps;

   function automatic bit legal(input logic [31:0] p);
      return (p[1:0] == 2'b00) && (p < ROM_BYTES);
   endfunction

   function automatic logic [4:0] word_of(input logic [31:0] p);
      return 5'((p >> 2) % ROM_WORDS);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Monitor: one expectation per checked cycle, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("valid", 32'(bus.instr_valid_o), 32'(e.valid));
         chk("fault", 32'(bus.fault_o), 32'(e.fault));
         chk("imem_addr", 32'(bus.imem_addr_o), 32'(e.addr));
         if (e.valid || e.rst) chk("instr_pc", bus.instr_pc_o, e.pc);
         if (e.valid) chk("instr", bus.instr_o, e.instr);
         if (e.chk_fpc) chk("fault_pc", bus.fault_pc_o, e.fpc);
`ifdef FETCH_PERF_CNT_EN
         chk("perf_fetch", perf_fetch, e.pf);
         chk("perf_stall", perf_stall, e.ps);
`endif
      end
   end

   // Hold reset two edges; the cycle after the first edge shows reset state
   task automatic do_reset(input bit st);
      exp_t e;
      rst_n = 1'b0;
      bus.stall_i = st;
      bus.redirect_i = 1'b0;
      bus.redirect_pc_i = '0;
      @(posedge clk); #1;
      e = '{rst: 1'b1, valid: 1'b0, pc: 32'h0, instr: 32'h0, fault: 1'b0,
            chk_fpc: 1'b1, fpc: 32'h0, addr: 5'd0, pf: 32'h0, ps: 32'h0};
      q.push_back(e);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_boot = 1; m_valid = 0; m_fault = 0;
      m_pc = 32'h0; m_nxt = 32'h0; m_fpc = 32'h0; m_pf = 32'h0; m_ps = 32'h0;
   endtask

   // One cycle of stimulus; expectation for this cycle, then model advance
   task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
      exp_t        e;
      logic [31:0] p;
      bit          adv;
      bus.stall_i = st;
      bus.redirect_i = rd;
      bus.redirect_pc_i = tgt;
      e.rst     = 1'b0;
      e.valid   = m_valid;
      e.pc      = m_pc;
      e.instr   = 32'h1000_0000 + (m_pc >> 2);
      e.fault   = m_fault;
      e.chk_fpc = m_fault;
      e.fpc     = m_fpc;
      if (rd)                 e.addr = word_of(tgt);
      else if (m_valid && st) e.addr = word_of(m_pc);
      else                    e.addr = word_of(m_nxt);
      e.pf = m_pf;
      e.ps = m_ps;
      q.push_back(e);
      if (m_valid && !rd) begin
         if (st) m_ps = m_ps + 1;
         else    m_pf = m_pf + 1;
      end
      adv = rd || m_boot || (m_valid && !st);
      p   = rd ? tgt : m_nxt;
      if (adv) begin
         m_boot = 0;
         if (legal(p)) begin
            m_valid = 1; m_fault = 0; m_pc = p; m_nxt = p + 32'd4;
         end else begin
            m_valid = 0; m_fault = 1; m_fpc = p;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_target();
      int unsigned r = $urandom_range(0, 99);
      if (r < 75)      return 32'($urandom_range(0, ROM_WORDS-1)) << 2;
      else if (r < 90) return 32'($urandom_range(0, 255));
      else             return $urandom;
   endfunction

   initial begin
      bit st, rd;
      bus.stall_i = 1'b0;
      bus.redirect_i = 1'b0;
      bus.redirect_pc_i = '0;

      // Sequential fetch, 3-cycle stall on PC 8
      do_reset(1'b0);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

      // Redirect at PC 4, then again with stall asserted together
      do_reset(1'b1);
      step(0, 0, 0); step(0, 0, 0); step(0, 1, 32'h40); step(0, 0, 0); step(0, 0, 0);
      do_reset(1'b0);
      step(0, 0, 0); step(0, 0, 0); step(1, 1, 32'h40); step(0, 0, 0);

      // Run off the end of the ROM, recover with a redirect
      step(0, 1, 32'h78); step(0, 0, 0); step(0, 0, 0);
      step(1, 0, 0); step(0, 0, 0);
      step(0, 1, 32'h0); step(0, 0, 0); step(0, 0, 0);

      // Misaligned redirect, illegal redirect while halted, reset out of HALT
      step(0, 1, 32'h42); step(1, 0, 0); step(0, 1, 32'h200); step(0, 0, 0);
      do_reset(1'b1);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

      // Random stall/redirect traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)));
         st = ($urandom_range(0, 99) < 30);
         rd = !m_boot && ($urandom_range(0, 99) < 12);
         step(st, rd, rd ? rand_target() : 32'($urandom));
      end

      @(negedge clk); #1;
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
